// File: rtl/jk_fsm_pkg.sv
// Shared types for the JK channel bank.
// State encoding and dwell counter width helper.
package jk_fsm_pkg;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } state_e;

  function automatic int dwell_w(input int min_on);
    int w;
    w = $clog2(min_on + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/jk_fsm_chan.sv
// One JK channel: OFF/ON state, minimum-ON dwell, rise pulse.
// Ports: clk, reset (sync, high), en, j, k -> out, rise.
import jk_fsm_pkg::*;

module jk_fsm_chan #(
  parameter int MIN_ON = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic out,
  output logic rise
);

  localparam int DW = dwell_w(MIN_ON);
  localparam logic [DW-1:0] DMAX = DW'(MIN_ON);

  state_e          state_q, state_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            out_dly_q, out_dly_d;

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    out_dly_d = out;
    if (en) begin
      unique case (state_q)
        OFF: begin
          if (j) begin
            state_d = ON;
            dwell_d = '0;
          end
        end
        ON: begin
          // k only honoured once the dwell has saturated
          if (k && (dwell_q == DMAX)) begin
            state_d = OFF;
          end else if (dwell_q != DMAX) begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= OFF;
      dwell_q   <= '0;
      out_dly_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      out_dly_q <= out_dly_d;
    end
  end

  assign out  = (state_q == ON);
  assign rise = out & ~out_dly_q;

endmodule

// File: rtl/jk_fsm_bank.sv
// Bank of NCH independent JK channels with registered aggregates.
// Ports: clk, reset, en/j/k[NCH] -> out, rise, on_count, any_on.
import jk_fsm_pkg::*;

module jk_fsm_bank #(
  parameter int NCH    = 4,
  parameter int MIN_ON = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCH-1:0]             en,
  input  logic [NCH-1:0]             j,
  input  logic [NCH-1:0]             k,
  output logic [NCH-1:0]             out,
  output logic [NCH-1:0]             rise,
  output logic [$clog2(NCH+1)-1:0]   on_count,
  output logic                       any_on
);

  localparam int CW = $clog2(NCH + 1);

  logic [CW-1:0] on_count_q, on_count_d;
  logic          any_on_q, any_on_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    jk_fsm_chan #(
      .MIN_ON(MIN_ON)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .en   (en[i]),
      .j    (j[i]),
      .k    (k[i]),
      .out  (out[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    on_count_d = '0;
    for (int i = 0; i < NCH; i++) begin
      on_count_d = on_count_d + CW'(out[i]);
    end
    any_on_d = |out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      on_count_q <= '0;
      any_on_q   <= 1'b0;
    end else begin
      on_count_q <= on_count_d;
      any_on_q   <= any_on_d;
    end
  end

  assign on_count = on_count_q;
  assign any_on   = any_on_q;

endmodule

// File: tb/tb_jk_fsm_bank.sv
// Directed vector bench for jk_fsm_bank (MIN_ON=3 and MIN_ON=0).
// Each row: inputs for one edge, outputs expected just after it.
module tb_jk_fsm_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en, j, k;
  logic [3:0] out, rise;
  logic [2:0] on_count;
  logic       any_on;

  logic [3:0] en0, j0, k0;
  logic [3:0] out0, rise0;
  logic [2:0] on_count0;
  logic       any_on0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_fsm_bank #(.NCH(4), .MIN_ON(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .j       (j),
    .k       (k),
    .out     (out),
    .rise    (rise),
    .on_count(on_count),
    .any_on  (any_on)
  );

  jk_fsm_bank #(.NCH(4), .MIN_ON(0)) dut0 (
    .clk     (clk),
    .reset   (reset),
    .en      (en0),
    .j       (j0),
    .k       (k0),
    .out     (out0),
    .rise    (rise0),
    .on_count(on_count0),
    .any_on  (any_on0)
  );

  typedef struct {
    logic       r;
    logic [3:0] en;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] out;
    logic [3:0] rise;
    logic [2:0] cnt;
    logic       any;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [3:0] e,
                     input logic [3:0] jj, input logic [3:0] kk,
                     input logic [3:0] o, input logic [3:0] rs,
                     input logic [2:0] c, input logic a);
    vec_t v;
    v.r = r; v.en = e; v.j = jj; v.k = kk;
    v.out = o; v.rise = rs; v.cnt = c; v.any = a;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int row,
                     input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h",
               name, row, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en = 4'hF; j = 4'h0; k = 4'h0;
    en0 = 4'hF; j0 = 4'h0; k0 = 4'h0;

    //   r  en     j      k      out    rise   cnt any
    // reset held with j all ones
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    // first cycle after reset, no j
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    // ch0 j pulse then k held: 4 ON cycles
    add(0, 4'hF, 4'h1, 4'h0, 4'h1, 4'h1, 3'd0, 0);
    add(0, 4'hF, 4'h0, 4'h1, 4'h1, 4'h0, 3'd1, 1);
    add(0, 4'hF, 4'h0, 4'h1, 4'h1, 4'h0, 3'd1, 1);
    add(0, 4'hF, 4'h0, 4'h1, 4'h1, 4'h0, 3'd1, 1);
    add(0, 4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 3'd1, 1);
    add(0, 4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 3'd0, 0);
    // ch2 j=k=1 held
    add(0, 4'hF, 4'h4, 4'h4, 4'h4, 4'h4, 3'd0, 0);
    add(0, 4'hF, 4'h4, 4'h4, 4'h4, 4'h0, 3'd1, 1);
    add(0, 4'hF, 4'h4, 4'h4, 4'h4, 4'h0, 3'd1, 1);
    add(0, 4'hF, 4'h4, 4'h4, 4'h4, 4'h0, 3'd1, 1);
    add(0, 4'hF, 4'h4, 4'h4, 4'h0, 4'h0, 3'd1, 1);
    add(0, 4'hF, 4'h4, 4'h4, 4'h4, 4'h4, 3'd0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h4, 4'h0, 3'd1, 1);
    // reset mid-dwell
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    // ch3 disabled with j for 5 cycles
    add(0, 4'h7, 4'h8, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    add(0, 4'h7, 4'h8, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    add(0, 4'h7, 4'h8, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    add(0, 4'h7, 4'h8, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    add(0, 4'h7, 4'h8, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    add(0, 4'hF, 4'h8, 4'h0, 4'h8, 4'h8, 3'd0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h8, 4'h0, 3'd1, 1);
    // disabled in ON: k ignored
    add(0, 4'h7, 4'h0, 4'h8, 4'h8, 4'h0, 3'd1, 1);
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    // all four channels at once, then reset mid-dwell
    add(0, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 3'd0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 3'd4, 1);
    add(0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 3'd4, 1);
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, 0);
    // dwell restarts from zero after reset
    add(0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 0);
    add(0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 3'd4, 1);
    add(0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 3'd4, 1);
    add(0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 3'd4, 1);
    add(0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 3'd4, 1);
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, 0);

    foreach (tv[i]) begin
      reset = tv[i].r;
      en    = tv[i].en;
      j     = tv[i].j;
      k     = tv[i].k;
      tick();
      chk("out",      i, out,      tv[i].out);
      chk("rise",     i, rise,     tv[i].rise);
      chk("on_count", i, {1'b0, on_count}, {1'b0, tv[i].cnt});
      chk("any_on",   i, {3'b0, any_on},   {3'b0, tv[i].any});
      chk("out0_idle", i, out0, 4'h0);
    end

    // MIN_ON=0: ch1 j then k gives a single ON cycle
    reset = 1'b0;
    en = 4'hF; j = 4'h0; k = 4'h0;
    j0 = 4'h2; k0 = 4'h0;
    tick();
    chk("m0_out_on",  100, out0,  4'h2);
    chk("m0_rise_on", 100, rise0, 4'h2);
    j0 = 4'h0; k0 = 4'h2;
    tick();
    chk("m0_out_off",  101, out0,      4'h0);
    chk("m0_cnt_off",  101, {1'b0, on_count0}, 4'h1);
    k0 = 4'h0;
    tick();
    chk("m0_out_stay", 102, out0,      4'h0);
    chk("m0_cnt_zero", 102, {1'b0, on_count0}, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
